// File: rtl/cpu_bus_decoder.sv
// cpu_bus_decoder: single-master to four-slave bus decoder with per-slave address windows.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   m_addr, m_read, m_write          CPU request (read wins if both high)
//   m_writedata, m_byteenable        CPU write data and byte lanes
//   m_readdata, m_response           completion data and response (00 OK, 10 SLVERR, 11 DECERR)
//   m_waitrequest                    low for exactly one cycle per completed transfer
//   s_addr, s_writedata, s_byteenable  registered request fields shared by all slaves
//   s_read, s_write                  one-hot per-slave strobes
//   s_readdata, s_response, s_waitrequest  packed per-slave returns (slave i in lane i)
//   err_valid, err_addr              one-cycle error pulse and faulting address
//
// Build option: define CPU_BUS_DECODER_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles with SLVERR; without it ACCESS waits indefinitely.
module cpu_bus_decoder #(
    parameter logic [127:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [127:0] SLAVE_MASK     = {4{32'hF000_0000}},
    parameter int           TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  m_addr,
    input  logic         m_read,
    input  logic         m_write,
    input  logic [31:0]  m_writedata,
    input  logic [3:0]   m_byteenable,
    output logic [31:0]  m_readdata,
    output logic [1:0]   m_response,
    output logic         m_waitrequest,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_writedata,
    output logic [3:0]   s_byteenable,
    output logic [3:0]   s_read,
    output logic [3:0]   s_write,
    input  logic [127:0] s_readdata,
    input  logic [7:0]   s_response,
    input  logic [3:0]   s_waitrequest,
    output logic         err_valid,
    output logic [31:0]  err_addr
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sel, hit_idx;
    logic        hit, req, done, tmo, tmo_q, is_write;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;

    assign req  = m_read | m_write;
    assign done = (state == ACCESS) && !s_waitrequest[sel];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

`ifdef CPU_BUS_DECODER_TIMEOUT_EN
    logic [15:0] cnt;

    // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 16'd0;
        else        cnt <= (state == ACCESS) ? cnt + 16'd1 : 16'd0;
    end

    assign tmo = (state == ACCESS) && s_waitrequest[sel] && (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        m_waitrequest = 1'b1;
        m_readdata    = 32'd0;
        m_response    = 2'b00;
        err_valid     = 1'b0;
        case (state)
            IDLE:    state_nxt = req ? (hit ? ACCESS : ERR) : IDLE;
            ACCESS:  state_nxt = (done || tmo) ? RESP : ACCESS;
            RESP: begin
                state_nxt     = IDLE;
                m_waitrequest = 1'b0;
                m_readdata    = rdata_q;
                m_response    = resp_q;
                err_valid     = tmo_q;
            end
            default: begin
                state_nxt     = IDLE;
                m_waitrequest = 1'b0;
                m_response    = 2'b11;
                err_valid     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= 2'd0;
            is_write     <= 1'b0;
            s_addr       <= 32'd0;
            s_writedata  <= 32'd0;
            s_byteenable <= 4'd0;
            s_read       <= 4'd0;
            s_write      <= 4'd0;
            rdata_q      <= 32'd0;
            resp_q       <= 2'b00;
            tmo_q        <= 1'b0;
            err_addr     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                s_addr       <= m_addr;
                s_writedata  <= m_writedata;
                s_byteenable <= m_byteenable;
                sel          <= hit_idx;
                is_write     <= !m_read;
                tmo_q        <= 1'b0;
                if (hit) begin
                    s_read  <= m_read ? 4'b0001 << hit_idx : 4'd0;
                    s_write <= m_read ? 4'd0 : 4'b0001 << hit_idx;
                end else begin
                    err_addr <= m_addr;
                end
            end
            if (state == ACCESS && (done || tmo)) begin
                s_read  <= 4'd0;
                s_write <= 4'd0;
                rdata_q <= (tmo || is_write) ? 32'd0 : s_readdata[{sel, 5'd0} +: 32];
                resp_q  <= tmo ? 2'b10 : s_response[{sel, 1'b0} +: 2];
                tmo_q   <= tmo;
                if (tmo) err_addr <= s_addr;
            end
        end
    end
endmodule
